// File: rtl/multicycle_controller.sv
// Control unit for the multicycle Armv4 datapath: Moore FSM, instruction decoder,
// condition check and NZCV flag register. Control outputs are registered per state.
module multicycle_controller #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [19:0] instruction,
   input  logic [3:0]  ALU_flags,
   output logic        pc_write,
   output logic        address_source,
   output logic        write_memory,
   output logic        ir_write,
   output logic        write_register,
   output logic [1:0]  result_source,
   output logic        ALU_source_a,
   output logic [1:0]  ALU_source_b,
   output logic [1:0]  ALU_control,
   output logic [1:0]  immediate_source,
   output logic [1:0]  register_source,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   state_t      state_q, state_n;
   logic [3:0]  flags_q;
   logic        cond_q;
   logic [11:0] ctrl_q;

   logic [3:0] cond, rd, cmd;
   logic [1:0] op;
   logic [5:0] funct;
   logic [1:0] alu_dec;
   logic       dp_writes, flag_en, logic_op, cond_now, cond_next;

   assign cond  = instruction[19:16];
   assign op    = instruction[15:14];
   assign funct = instruction[13:8];
   assign rd    = instruction[3:0];
   assign cmd   = funct[4:1];

   function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         4'h0: cond_pass = z;
         4'h1: cond_pass = !z;
         4'h2: cond_pass = c;
         4'h3: cond_pass = !c;
         4'h4: cond_pass = n;
         4'h5: cond_pass = !n;
         4'h6: cond_pass = v;
         4'h7: cond_pass = !v;
         4'h8: cond_pass = c & !z;
         4'h9: cond_pass = !c | z;
         4'hA: cond_pass = (n == v);
         4'hB: cond_pass = (n != v);
         4'hC: cond_pass = !z & (n == v);
         4'hD: cond_pass = z | (n != v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   // Layout: {pc_write, address_source, write_memory, ir_write, write_register,
   //          result_source[1:0], ALU_source_a, ALU_source_b[1:0], ALU_control[1:0]}
   function automatic logic [11:0] ctrl_for(input state_t s, input logic c,
                                            input logic [1:0] alu, input logic dpw,
                                            input logic rd_pc);
      logic       pcw, adr, wm, irw, wr, sa;
      logic [1:0] rs, sb, ac;
      {pcw, adr, wm, irw, wr, sa} = '0;
      rs = 2'b00; sb = 2'b00; ac = 2'b00;
      case (s)
         FETCH:    begin irw = 1'b1; pcw = 1'b1; sa = 1'b1; sb = 2'b10; rs = 2'b10; end
         DECODE:   begin sa = 1'b1; sb = 2'b10; rs = 2'b10; end
         MEMADR:   sb = 2'b01;
         MEMREAD:  adr = 1'b1;
         MEMWRITE: begin adr = 1'b1; wm = c; end
         MEMWB:    begin rs = 2'b01; wr = c & !rd_pc; pcw = c & rd_pc; end
         EXECR:    ac = alu;
         EXECI:    begin sb = 2'b01; ac = alu; end
         ALUWB:    begin wr = c & dpw & !rd_pc; pcw = c & dpw & rd_pc; end
         BRANCH:   begin sb = 2'b01; rs = 2'b10; pcw = c; end
         default:  ;
      endcase
      ctrl_for = {pcw, adr, wm, irw, wr, rs, sa, sb, ac};
   endfunction

   always_comb begin
      alu_dec   = 2'b00;
      dp_writes = 1'b0;
      flag_en   = 1'b0;
      logic_op  = 1'b0;
      case (cmd)
         4'b0100: begin alu_dec = 2'b00; dp_writes = 1'b1; flag_en = funct[0]; end
         4'b0010: begin alu_dec = 2'b01; dp_writes = 1'b1; flag_en = funct[0]; end
         4'b0000: begin alu_dec = 2'b10; dp_writes = 1'b1; flag_en = funct[0]; logic_op = 1'b1; end
         4'b1100: begin alu_dec = 2'b11; dp_writes = 1'b1; flag_en = funct[0]; logic_op = 1'b1; end
         4'b1010: begin alu_dec = 2'b01; flag_en = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      state_n = FETCH;
      case (state_q)
         FETCH:   state_n = DECODE;
         DECODE:  case (op)
                     2'b01:   state_n = MEMADR;
                     2'b00:   state_n = funct[5] ? EXECI : EXECR;
                     2'b10:   state_n = BRANCH;
                     default: state_n = FETCH;
                  endcase
         MEMADR:  state_n = funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD: state_n = MEMWB;
         EXECR,
         EXECI:   state_n = ALUWB;
         default: state_n = FETCH;
      endcase
   end

   // The condition is latched leaving DECODE, so the first registered outputs
   // after DECODE must use the freshly evaluated result rather than cond_q.
   assign cond_now  = cond_pass(cond, flags_q);
   assign cond_next = (state_q == DECODE) ? cond_now : cond_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= FETCH;
         flags_q <= RESET_FLAGS;
         cond_q  <= 1'b0;
         ctrl_q  <= ctrl_for(FETCH, 1'b0, 2'b00, 1'b0, 1'b0);
      end else begin
         state_q <= state_n;
         ctrl_q  <= ctrl_for(state_n, cond_next, alu_dec, dp_writes, rd == 4'hF);
         if (state_q == DECODE)
            cond_q <= cond_now;
         if ((state_q == EXECR || state_q == EXECI) && cond_q && flag_en) begin
            if (logic_op) flags_q[3:2] <= ALU_flags[3:2];
            else          flags_q      <= ALU_flags;
         end
      end
   end

   assign pc_write         = ctrl_q[11] & !reset;
   assign address_source   = ctrl_q[10];
   assign write_memory     = ctrl_q[9] & !reset;
   assign ir_write         = ctrl_q[8] & !reset;
   assign write_register   = ctrl_q[7] & !reset;
   assign result_source    = ctrl_q[6:5];
   assign ALU_source_a     = ctrl_q[4];
   assign ALU_source_b     = ctrl_q[3:2];
   assign ALU_control      = ctrl_q[1:0];
   assign immediate_source = (op == 2'b11) ? 2'b00 : op;
   assign register_source  = {(op == 2'b01) & !funct[0], op == 2'b10};
   assign state            = state_q;

endmodule
